mdu_pipelined: RTL and testbench
================================

Name: mdu_pipelined

Overview:
- Parametrised multiply/divide unit for the EX stage of the five-stage pipeline.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over a configurable number of cycles; MTHI/MTLO take a single cycle.
- Drives busy to the hazard unit, which stalls MDU-class instructions in D while start or busy is high.
- Differs from the previous MDU in three ways: operand width and per-class latency are parameters, a flush input cancels an in-flight operation, and a done pulse marks completion.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 2.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be at least 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- start  in  1  operation request, sampled at the clk edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- a  in  WIDTH  rs operand (forwarded value).
- b  in  WIDTH  rt operand (forwarded value).
- flush  in  1  cancels the in-flight operation.
- busy  out  1  long operation in progress.
- done  out  1  one-cycle pulse when HI/LO take a long-operation result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, done=0, cycle counter=0, latched result=0. Reset mid-operation abandons the operation and produces no done.
- State machine has two states, IDLE and RUN.
- IDLE, start=1, op in 0..3, flush=0: at that edge, compute the product or quotient/remainder from a and b, latch it, load the counter with N-1, and go to RUN. busy=1 from the following cycle.
  - N=MULT_CYCLES for MULT/MULTU; N=DIV_CYCLES for DIV/DIVU.
- RUN: the counter decrements each edge. busy is high for exactly N cycles.
  - At the edge where the counter is 0: hi and lo take the latched result, state returns to IDLE, busy=0, and done=1 for one cycle.
  - A start sampled on the edge where hi/lo update is ignored; the hazard unit guarantees no such request occurs.
- MTHI/MTLO (op 4/5, start=1, state IDLE, flush=0): hi (or lo) takes a at that edge. busy stays 0 and done stays 0.
- start while in RUN: ignored.
- op 6 or 7: ignored.
- flush=1:
  - In RUN, the next edge returns to IDLE with busy=0, hi/lo unchanged and no done.
  - Same cycle as start: flush wins and start is ignored.
  - In IDLE with no start: no effect.
- Result arithmetic, WIDTH=W:
  - MULT: signed W x W to a 2W product; hi=upper W bits, lo=lower W bits.
  - MULTU: unsigned product, split the same way.
  - DIV: signed, quotient truncates toward zero; lo=quotient, hi=remainder, remainder takes the dividend's sign.
  - DIVU: unsigned; lo=quotient, hi=remainder.
- Division boundaries:
  - b==0: lo = all ones, hi = a (both DIV and DIVU).
  - DIV with a=most-negative and b=-1: lo=a, hi=0.
- Operands are captured on the start edge; later changes to a and b do not affect the result.
- hi and lo are registered outputs and change only at the edges named above.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7, defaults -> busy high 5 cycles; at the falling edge hi=0xFFFFFFFF, lo=0xFFFFFFEB; done=1 for exactly one cycle.
- DIVU a=100, b=7 -> busy high 10 cycles, then lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide boundaries: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- MTHI a=0x1234 -> hi=0x1234 the next cycle with busy=0 and done=0. Then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Start a MULT, change a and b on the next cycle, then assert flush in the 3rd busy cycle -> busy=0 the next cycle, hi/lo keep their previous values, no done pulse. Separately, start and flush in the same cycle -> busy never rises.
- Parameter sweep with MULT_CYCLES=1, DIV_CYCLES=1, and WIDTH=16 -> busy lasts exactly one cycle. For WIDTH=16, MULT 0x8000 x 0x8000 gives hi=0x4000, lo=0. Applying reset==0 mid-DIV gives hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/mdu_pipelined.sv
// mdu_pipelined: multiply/divide unit for the EX stage.
// Owns the HI/LO registers. MULT/MULTU/DIV/DIVU compute their result at
// the start edge, hold it in a latch register and commit it to HI/LO after
// MULT_CYCLES / DIV_CYCLES busy cycles. MTHI/MTLO write HI/LO in one cycle.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low reset
//   start  - operation request, sampled at the clk edge
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a, b   - rs / rt operands (forwarded values)
//   flush  - cancels an in-flight long operation
//   busy   - long operation in progress
//   done   - one-cycle pulse when HI/LO take a long-operation result
//   hi, lo - HI and LO registers
module mdu_pipelined #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   res_hi_r;
    logic [WIDTH-1:0]   res_lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               mul_signed_s;
    logic               div_signed_s;
    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   dvd_mag_s;
    logic [WIDTH-1:0]   dvs_mag_s;
    logic [WIDTH-1:0]   q_mag_s;
    logic [WIDTH-1:0]   r_mag_s;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Result datapath: one 2W multiplier and one unsigned divider on magnitudes.
    always_comb begin
        mul_signed_s = (op == OP_MULT);
        div_signed_s = (op == OP_DIV);
        // Sign-extending to 2W makes the low 2W bits of the unsigned product
        // equal to the signed product, so one multiplier serves both forms.
        a_ext_s = {{WIDTH{a[WIDTH-1] & mul_signed_s}}, a};
        b_ext_s = {{WIDTH{b[WIDTH-1] & mul_signed_s}}, b};
        prod_s  = a_ext_s * b_ext_s;

        // The most-negative dividend's magnitude still fits as unsigned W bits,
        // so min / -1 falls out naturally as quotient = a, remainder = 0.
        a_neg_s   = div_signed_s & a[WIDTH-1];
        b_neg_s   = div_signed_s & b[WIDTH-1];
        dvd_mag_s = a_neg_s ? (-a) : a;
        dvs_mag_s = b_neg_s ? (-b) : b;
        if (dvs_mag_s != {WIDTH{1'b0}}) begin
            q_mag_s = dvd_mag_s / dvs_mag_s;
            r_mag_s = dvd_mag_s % dvs_mag_s;
        end else begin
            q_mag_s = {WIDTH{1'b0}};
            r_mag_s = {WIDTH{1'b0}};
        end
        q_s = (a_neg_s ^ b_neg_s) ? (-q_mag_s) : q_mag_s;
        r_s = a_neg_s ? (-r_mag_s) : r_mag_s;

        if (op[1] == 1'b0) begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else if (b == {WIDTH{1'b0}}) begin
            res_hi_s = a;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = r_s;
            res_lo_s = q_s;
        end
    end

    // Control FSM with HI/LO, latched result, counter and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            res_lo_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // flush wins over a same-cycle start
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                res_hi_r <= res_hi_s;
                                res_lo_r <= res_lo_s;
                                cnt_r    <= op[1] ? DIV_LOAD : MULT_LOAD;
                                busy_r   <= 1'b1;
                                state_r  <= ST_RUN;
                            end
                            OP_MTHI: hi_r <= a;
                            OP_MTLO: lo_r <= a;
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        hi_r    <= res_hi_r;
                        lo_r    <= res_lo_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_pipelined.sv
// Scoreboard bench for mdu_pipelined: a default instance (W=32, 5/10 cycles)
// and a swept instance (W=16, 1/1 cycles). Stimulus pushes expected HI/LO
// into a queue; per-instance monitors pop and compare on every done pulse.
module tb_mdu_pipelined;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        start0 = 1'b0, flush0 = 1'b0;
    logic [2:0]  op0 = 3'd0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0;
    logic        busy0, done0;
    logic [31:0] hi0, lo0;

    logic        start1 = 1'b0, flush1 = 1'b0;
    logic [2:0]  op1 = 3'd0;
    logic [15:0] a1 = 16'd0, b1 = 16'd0;
    logic        busy1, done1;
    logic [15:0] hi1, lo1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_pipelined dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
        .flush(flush0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    mdu_pipelined #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
        .flush(flush1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut0_unexpected_done: got done=1, expected no done");
            end else begin
                e0 = q0.pop_front();
                chk("dut0_hilo", {hi0, lo0}, {e0.hi, e0.lo});
            end
        end
    end

    // Monitor for the swept instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut1_unexpected_done: got done=1, expected no done");
            end else begin
                e1 = q1.pop_front();
                chk("dut1_hilo", {16'd0, hi1, 16'd0, lo1}, {e1.hi, e1.lo});
            end
        end
    end

    // Issue a long operation, scramble operands afterwards, count busy cycles.
    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh,
                          input logic [31:0] el, input int n, input string name);
        int   cnt;
        exp_t e;
        @(negedge clk);
        e.hi = eh;
        e.lo = el;
        if (sel) begin
            start1 = 1'b1; op1 = o; a1 = av[15:0]; b1 = bv[15:0];
            q1.push_back(e);
        end else begin
            start0 = 1'b1; op0 = o; a0 = av; b0 = bv;
            q0.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        a0 = $urandom;
        b0 = $urandom;
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        cnt = 0;
        while ((sel ? busy1 : busy0) === 1'b1 && cnt < 64) begin
            cnt++;
            // a start while RUN must be ignored
            if (!sel && cnt == 2 && n >= 3) begin
                start0 = 1'b1;
                op0 = 3'd4;
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        chk({name, "_busy_cycles"}, 64'(cnt), 64'(n));
        @(negedge clk);
        chk({name, "_sb_drained"}, 64'(sel ? q1.size() : q0.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hi", 64'(hi0), 64'd0);
        chk("reset_lo", 64'(lo0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        reset = 1'b1;

        run_op(1'b0, 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, "mult_neg3x7");
        run_op(1'b0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu_100_7");
        run_op(1'b0, 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2");
        run_op(1'b0, 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, "div_7_m2");
        run_op(1'b0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, "div_min_m1");
        run_op(1'b0, 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 10, "divu_by0");
        run_op(1'b0, 3'd2, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 10, "div_by0");

        run_op(1'b1, 3'd0, 32'h8000, 32'h8000, 32'h4000, 32'h0000, 1, "w16_mult_min");
        run_op(1'b1, 3'd2, 32'hFFF9, 32'h0002, 32'hFFFF, 32'hFFFD, 1, "w16_div_m7_2");
        run_op(1'b1, 3'd3, 32'h8000, 32'h0000, 32'h8000, 32'hFFFF, 1, "w16_divu_by0");
        run_op(1'b1, 3'd1, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 1, "w16_multu_max");

        // MTHI / MTLO
        @(negedge clk);
        start0 = 1'b1; op0 = 3'd4; a0 = 32'h1234;
        @(negedge clk);
        start0 = 1'b0;
        chk("mthi_hi", 64'(hi0), 64'h1234);
        chk("mthi_busy", 64'(busy0), 64'd0);
        chk("mthi_done", 64'(done0), 64'd0);
        start0 = 1'b1; op0 = 3'd5; a0 = 32'h5678;
        @(negedge clk);
        start0 = 1'b0;
        chk("mtlo_lo", 64'(lo0), 64'h5678);
        chk("mtlo_hi_kept", 64'(hi0), 64'h1234);

        // op 6 is a no-op
        start0 = 1'b1; op0 = 3'd6; a0 = 32'hDEAD; b0 = 32'hBEEF;
        @(negedge clk);
        start0 = 1'b0;
        chk("nop_busy", 64'(busy0), 64'd0);
        chk("nop_hilo", {hi0, lo0}, {32'h1234, 32'h5678});

        run_op(1'b0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, "multu_max");

        // flush in the third busy cycle, operands changed after start
        @(negedge clk);
        start0 = 1'b1; op0 = 3'd0; a0 = 32'd3; b0 = 32'd5;
        @(negedge clk);
        start0 = 1'b0; a0 = 32'd9; b0 = 32'd9;
        @(negedge clk);
        @(negedge clk);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        chk("flush_busy", 64'(busy0), 64'd0);
        chk("flush_hilo_kept", {hi0, lo0}, {32'hFFFFFFFE, 32'h00000001});
        repeat (8) @(negedge clk);
        chk("flush_hilo_later", {hi0, lo0}, {32'hFFFFFFFE, 32'h00000001});

        // start and flush in the same cycle
        start0 = 1'b1; flush0 = 1'b1; op0 = 3'd2; a0 = 32'd50; b0 = 32'd3;
        @(negedge clk);
        start0 = 1'b0; flush0 = 1'b0;
        seen = 0;
        repeat (12) begin
            if (busy0 !== 1'b0) seen = 1;
            @(negedge clk);
        end
        chk("start_flush_busy_seen", 64'(seen), 64'd0);

        // reset in the middle of a DIV
        start0 = 1'b1; op0 = 3'd2; a0 = 32'd100; b0 = 32'd3;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_hilo", {hi0, lo0}, 64'd0);
        chk("midreset_busy", 64'(busy0), 64'd0);
        repeat (15) @(negedge clk);
        chk("midreset_busy_later", 64'(busy0), 64'd0);
        chk("final_q0_empty", 64'(q0.size()), 64'd0);
        chk("final_q1_empty", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
